// File: rtl/segway_pkg.sv
// segway_pkg: shared state encoding and soft-start limits for the power sequencer
package segway_pkg;
  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RAMP_UP = 2'd1,
    RUN     = 2'd2,
    RAMP_DN = 2'd3
  } seq_state_t;
  localparam logic [7:0] SS_MAX = 8'hFF;
  localparam logic [7:0] SS_MIN = 8'h00;
endpackage

// File: rtl/seq_persist_cnt.sv
// seq_persist_cnt: flags that lvl has been high with en set for 2^W consecutive clocks
module seq_persist_cnt #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic lvl,
  output logic done
);
  logic [W-1:0] cnt;
  // count qualified cycles; the all-ones count marks the 2^W-th one and then holds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (!(en && lvl)) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (&cnt) done <= 1'b1;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/segway_pwr_seq.sv
// segway_pwr_seq: power/soft-start sequencer; SEGWAY_SEQ_OVR_ALARM_EN builds the overspeed alarm
module segway_pwr_seq
  import segway_pkg::*;
#(
  parameter int SS_DIV_W = 12,
  parameter int STEER_W  = 16,
  parameter int OVR_W    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_btn,
  input  logic       rider_on,
  input  logic       steer_ok,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       en_steer,
  output logic       ovr_alarm,
  output logic [1:0] seq_state
);
  seq_state_t st;
  logic [SS_DIV_W-1:0] pre;
  logic btn_off, wrap, run_hold;
  assign wrap      = &pre;
  assign run_hold  = (st == RUN) && rider_on && !pwr_btn;
  assign seq_state = st;
  // sequencer: ramp scale on prescaler wraps, prescaler restarts on every state change
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= OFF;
      ss_tmr  <= SS_MIN;
      pwr_up  <= 1'b0;
      btn_off <= 1'b0;
      pre     <= '0;
    end else begin
      pre <= pre + 1'b1;
      case (st)
        OFF:
          if (pwr_btn && rider_on) begin
            st     <= RAMP_UP;
            pwr_up <= 1'b1;
            pre    <= '0;
          end
        RAMP_UP, RUN:
          if (pwr_btn || !rider_on) begin
            st      <= RAMP_DN;
            btn_off <= pwr_btn;
            pre     <= '0;
          end else if (st == RAMP_UP && wrap) begin
            ss_tmr <= (ss_tmr >= SS_MAX - 8'd1) ? SS_MAX : ss_tmr + 8'd1;
            if (ss_tmr >= SS_MAX - 8'd1) begin
              st  <= RUN;
              pre <= '0;
            end
          end
        RAMP_DN:
          if (rider_on && !btn_off) begin
            st  <= RAMP_UP;
            pre <= '0;
          end else if (wrap) begin
            ss_tmr <= (ss_tmr <= SS_MIN + 8'd1) ? SS_MIN : ss_tmr - 8'd1;
            if (ss_tmr <= SS_MIN + 8'd1) begin
              st     <= OFF;
              pwr_up <= 1'b0;
              pre    <= '0;
            end
          end
      endcase
    end
  // steering qualifies only while RUN is held this cycle, so it drops on the edge RUN is left
  seq_persist_cnt #(.W(STEER_W)) u_steer (
    .clk, .rst_n, .en(run_hold), .lvl(steer_ok), .done(en_steer)
  );
`ifdef SEGWAY_SEQ_OVR_ALARM_EN
  logic ovr_set, ovr_clr, going_off;
  assign going_off = (st == RAMP_DN) && wrap && (ss_tmr <= SS_MIN + 8'd1) && !(rider_on && !btn_off);
  seq_persist_cnt #(.W(OVR_W)) u_ovr_set (
    .clk, .rst_n, .en(st != OFF), .lvl(too_fast), .done(ovr_set)
  );
  seq_persist_cnt #(.W(OVR_W)) u_ovr_clr (
    .clk, .rst_n, .en(st != OFF), .lvl(!too_fast), .done(ovr_clr)
  );
  // alarm latches on sustained overspeed, releases on sustained calm, never survives into OFF
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovr_alarm <= 1'b0;
    else ovr_alarm <= (st == OFF || going_off) ? 1'b0 : ovr_set ? 1'b1 : ovr_clr ? 1'b0 : ovr_alarm;
`else
  logic [OVR_W:0] unused_ovr;
  assign unused_ovr = {too_fast, {OVR_W{1'b0}}};
  assign ovr_alarm  = 1'b0;
`endif
endmodule

// File: tb/tb_segway_pwr_seq.sv
// tb_segway_pwr_seq: directed and randomized checks of segway_pwr_seq against a reference model
module tb_segway_pwr_seq;
  localparam int DIV = 16, QUAL = 8, PERS = 4;
  localparam int S_OFF = 0, S_UP = 1, S_RUN = 2, S_DN = 3;
`ifdef SEGWAY_SEQ_OVR_ALARM_EN
  localparam int ALARM_EN = 1;
`else
  localparam int ALARM_EN = 0;
`endif
  typedef struct packed {
    int st;
    int ss;
    int boff;
  } nxt_t;
  logic clk = 1'b0, rst_n = 1'b0, pwr_btn = 1'b0, rider_on = 1'b0, steer_ok = 1'b0, too_fast = 1'b0;
  logic pwr_up, en_steer, ovr_alarm;
  logic [7:0] ss_tmr;
  logic [1:0] seq_state;
  int n_pass = 0, n_chk = 0;
  int m_st, m_ss, m_age, m_boff, m_qual, m_hi, m_lo, m_al;
  nxt_t nx;

  segway_pwr_seq #(.SS_DIV_W(4), .STEER_W(3), .OVR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .pwr_btn(pwr_btn), .rider_on(rider_on), .steer_ok(steer_ok),
    .too_fast(too_fast), .pwr_up(pwr_up), .ss_tmr(ss_tmr), .en_steer(en_steer),
    .ovr_alarm(ovr_alarm), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at time %0t", tag, got, exp, $time);
  endtask

  // scale moves one step per 16 cycles spent in a ramp state, clamped to 0..255
  function automatic nxt_t step(input int st, input int ss, input int boff, input int age,
                                input logic btn, input logic rider);
    nxt_t n;
    logic tick16;
    n = '{st: st, ss: ss, boff: boff};
    tick16 = (age % DIV) == DIV - 1;
    if (st == S_OFF) begin
      if (btn && rider) n.st = S_UP;
    end else if (st != S_DN) begin
      if (btn || !rider) begin
        n.st = S_DN;
        n.boff = int'(btn);
      end else if (st == S_UP && tick16) begin
        n.ss = (ss + 1 > 255) ? 255 : ss + 1;
        if (n.ss == 255) n.st = S_RUN;
      end
    end else if (rider && boff == 0) n.st = S_UP;
    else if (tick16) begin
      n.ss = (ss > 0) ? ss - 1 : 0;
      if (n.ss == 0) n.st = S_OFF;
    end
    return n;
  endfunction

  always_comb nx = step(m_st, m_ss, m_boff, m_age, pwr_btn, rider_on);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_st <= S_OFF; m_ss <= 0; m_age <= 0; m_boff <= 0;
      m_qual <= 0; m_hi <= 0; m_lo <= 0; m_al <= 0;
    end else begin
      m_st   <= nx.st;
      m_ss   <= nx.ss;
      m_boff <= nx.boff;
      m_age  <= (nx.st != m_st) ? 0 : m_age + 1;
      m_qual <= (m_st == S_RUN && rider_on && !pwr_btn && steer_ok) ? m_qual + 1 : 0;
      m_hi   <= (m_st != S_OFF && too_fast) ? m_hi + 1 : 0;
      m_lo   <= (m_st != S_OFF && !too_fast) ? m_lo + 1 : 0;
      m_al   <= (ALARM_EN == 0 || nx.st == S_OFF) ? 0 : (m_hi >= PERS) ? 1 : (m_lo >= PERS) ? 0 : m_al;
    end

  always @(negedge clk)
    if (rst_n) begin
      check("pwr_up", int'(pwr_up), int'(m_st != S_OFF));
      check("ss_tmr", int'(ss_tmr), m_ss);
      check("seq_state", int'(seq_state), m_st);
      check("en_steer", int'(en_steer), int'(m_qual >= QUAL));
      check("ovr_alarm", int'(ovr_alarm), m_al);
    end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_btn();
    pwr_btn = 1'b1;
    tick(1);
    pwr_btn = 1'b0;
  endtask

  task automatic wait_ss(input int target, input int budget);
    int i = 0;
    while (int'(ss_tmr) != target && i < budget) begin
      tick(1);
      i++;
    end
    check("wait_ss", int'(ss_tmr), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_pwr", int'(pwr_up), 0);
    check("rst_ss", int'(ss_tmr), 0);
    check("rst_state", int'(seq_state), S_OFF);
    check("rst_steer", int'(en_steer), 0);
    check("rst_alarm", int'(ovr_alarm), 0);
    rst_n = 1'b1;
    rider_on = 1'b1;
    tick(7);
    pulse_btn();
    check("up_pwr", int'(pwr_up), 1);
    check("up_state", int'(seq_state), S_UP);
    check("up_ss", int'(ss_tmr), 0);
    tick(15);
    check("ss_before_first", int'(ss_tmr), 0);
    tick(1);
    check("ss_first", int'(ss_tmr), 1);
    tick(4063);
    check("ramp_last_ss", int'(ss_tmr), 254);
    check("ramp_last_state", int'(seq_state), S_UP);
    tick(1);
    check("run_ss", int'(ss_tmr), 255);
    check("run_state", int'(seq_state), S_RUN);
    steer_ok = 1'b1;
    tick(7);
    check("steer_early", int'(en_steer), 0);
    tick(1);
    check("steer_on", int'(en_steer), 1);
    steer_ok = 1'b0;
    tick(1);
    check("steer_off", int'(en_steer), 0);
    pulse_btn();
    check("dn_state", int'(seq_state), S_DN);
    check("dn_pwr", int'(pwr_up), 1);
    for (int i = 0; i < 4078; i++) begin
      rider_on = 1'($urandom);
      tick(1);
    end
    rider_on = 1'b1;
    tick(1);
    check("dn_last_ss", int'(ss_tmr), 1);
    check("dn_last_state", int'(seq_state), S_DN);
    tick(1);
    check("off_ss", int'(ss_tmr), 0);
    check("off_state", int'(seq_state), S_OFF);
    check("off_pwr", int'(pwr_up), 0);
    tick(2);
    pulse_btn();
    wait_ss(8'h40, 1100);
    rider_on = 1'b0;
    tick(1);
    check("rdn_state", int'(seq_state), S_DN);
    check("rdn_ss", int'(ss_tmr), 8'h40);
    tick(15);
    check("rdn_hold", int'(ss_tmr), 8'h40);
    tick(1);
    check("rdn_step", int'(ss_tmr), 8'h3F);
    wait_ss(8'h30, 300);
    rider_on = 1'b1;
    tick(1);
    check("resume_state", int'(seq_state), S_UP);
    check("resume_ss", int'(ss_tmr), 8'h30);
    tick(15);
    check("resume_hold", int'(ss_tmr), 8'h30);
    tick(1);
    check("resume_step", int'(ss_tmr), 8'h31);
    too_fast = 1'b1;
    tick(3);
    too_fast = 1'b0;
    tick(1);
    check("ovr_short", int'(ovr_alarm), 0);
    tick(3);
    check("ovr_short_late", int'(ovr_alarm), 0);
    too_fast = 1'b1;
    tick(4);
    too_fast = 1'b0;
    tick(1);
    check("ovr_set", int'(ovr_alarm), ALARM_EN);
    tick(3);
    check("ovr_hold", int'(ovr_alarm), ALARM_EN);
    tick(1);
    check("ovr_clear", int'(ovr_alarm), 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    pulse_btn();
    too_fast = 1'b1;
    wait_ss(8'h22, 600);
    check("pre_rst_alarm", int'(ovr_alarm), ALARM_EN);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwr", int'(pwr_up), 0);
    check("arst_ss", int'(ss_tmr), 0);
    check("arst_state", int'(seq_state), S_OFF);
    check("arst_steer", int'(en_steer), 0);
    check("arst_alarm", int'(ovr_alarm), 0);
    too_fast = 1'b0;
    tick(1);
    rst_n = 1'b1;
    rider_on = 1'b0;
    pulse_btn();
    check("norider_state", int'(seq_state), S_OFF);
    check("norider_pwr", int'(pwr_up), 0);
    tick(2);
    check("norider_stay", int'(seq_state), S_OFF);
    rider_on = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      pwr_btn = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 2499) == 0) rider_on = !rider_on;
      if ($urandom_range(0, 19) == 0) steer_ok = !steer_ok;
      if ($urandom_range(0, 3) == 0) too_fast = !too_fast;
      tick(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
